// File: rtl/ili9341_fill_engine.sv
// ILI9341 rectangle fill sequencer: memory-mapped registers on the picosoc iomem bus,
// emits CASET/PASET/RAMWR and N RGB565 pixels on the 8-bit parallel write bus.
module ili9341_fill_engine #(
  parameter int unsigned HALF  = 1,
  parameter int unsigned MAX_X = 320,
  parameter int unsigned MAX_Y = 320
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  output logic        cmd_data,
  output logic        write_edge,
  output logic [7:0]  dout,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, SETUP, PIXEL} state_t;
  state_t r_state, w_state_nxt;

  logic [8:0]  r_x0, r_x1, r_y0, r_y1;
  logic [15:0] r_color;
  logic        r_err, r_abort_pend;
  logic [16:0] r_count;
  logic [3:0]  r_idx, r_half_cnt;
  logic        r_phase;
  logic        r_ready, r_cmd, r_we, r_done;
  logic [31:0] r_rdata;
  logic [7:0]  r_dout;

  logic        w_access, w_wr, w_rd, w_ctrl_wr, w_busy;
  logic        w_start_req, w_range_bad, w_start_ok, w_start_err, w_abort;
  logic        w_half_end, w_byte_end, w_load, w_fin, w_dec;
  logic [7:0]  w_reg;
  logic [3:0]  w_load_idx;
  logic [8:0]  w_setup_sel, w_load_byte;
  logic [9:0]  w_width, w_height;
  logic [16:0] w_npix;
  logic [31:0] w_rd_mux;
  logic        w_unused;

  assign w_reg       = iomem_addr[7:0];
  assign w_access    = iomem_valid && !r_ready;
  assign w_wr        = w_access && (|iomem_wstrb);
  assign w_rd        = w_access && !(|iomem_wstrb);
  assign w_ctrl_wr   = w_wr && (w_reg == 8'h0C) && iomem_wstrb[0];
  assign w_busy      = (r_state != IDLE);
  assign w_start_req = w_ctrl_wr && iomem_wdata[0] && !iomem_wdata[1] && !w_busy;
  assign w_range_bad = (r_x1 < r_x0) || (r_y1 < r_y0) ||
                       (32'(r_x1) >= MAX_X) || (32'(r_y1) >= MAX_Y);
  assign w_start_ok  = w_start_req && !w_range_bad;
  assign w_start_err = w_start_req && w_range_bad;
  assign w_abort     = w_busy && (r_abort_pend || (w_ctrl_wr && iomem_wdata[1]));
  assign w_half_end  = (r_half_cnt == 4'(HALF - 1));
  assign w_byte_end  = w_busy && r_phase && w_half_end;
  assign w_width     = {1'b0, r_x1} - {1'b0, r_x0} + 10'd1;
  assign w_height    = {1'b0, r_y1} - {1'b0, r_y0} + 10'd1;
  assign w_npix      = 17'(w_width) * 17'(w_height);
  assign w_unused    = ^{iomem_addr[31:8], iomem_wdata[31:25]};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  // Byte sequencing only advances on the edge that ends phase B, so a strobe is never cut short.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_load_idx  = r_idx;
    w_fin       = 1'b0;
    case (r_state)
      IDLE: if (w_start_ok) begin
        w_state_nxt = SETUP;
        w_load      = 1'b1;
        w_load_idx  = 4'd0;
      end
      SETUP: if (w_byte_end) begin
        if (w_abort) w_state_nxt = IDLE;
        else if (r_idx == 4'd10) begin
          w_state_nxt = PIXEL;
          w_load      = 1'b1;
          w_load_idx  = 4'd0;
        end else begin
          w_load     = 1'b1;
          w_load_idx = r_idx + 4'd1;
        end
      end
      PIXEL: if (w_byte_end) begin
        if (w_abort) w_state_nxt = IDLE;
        else if (!r_idx[0]) begin
          w_load     = 1'b1;
          w_load_idx = 4'd1;
        end else if (r_count == 17'd1) begin
          w_state_nxt = IDLE;
          w_fin       = 1'b1;
        end else begin
          w_load     = 1'b1;
          w_load_idx = 4'd0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_dec = (r_state == PIXEL) && w_byte_end && r_idx[0] && !w_abort;

  // {cmd_data, byte} for each header position; high bytes zero-extend the 9-bit coordinates.
  always_comb begin
    w_setup_sel = {1'b1, 8'h00};
    case (w_load_idx)
      4'd0:    w_setup_sel = {1'b0, 8'h2A};
      4'd1:    w_setup_sel = {1'b1, 7'b0, r_x0[8]};
      4'd2:    w_setup_sel = {1'b1, r_x0[7:0]};
      4'd3:    w_setup_sel = {1'b1, 7'b0, r_x1[8]};
      4'd4:    w_setup_sel = {1'b1, r_x1[7:0]};
      4'd5:    w_setup_sel = {1'b0, 8'h2B};
      4'd6:    w_setup_sel = {1'b1, 7'b0, r_y0[8]};
      4'd7:    w_setup_sel = {1'b1, r_y0[7:0]};
      4'd8:    w_setup_sel = {1'b1, 7'b0, r_y1[8]};
      4'd9:    w_setup_sel = {1'b1, r_y1[7:0]};
      4'd10:   w_setup_sel = {1'b0, 8'h2C};
      default: w_setup_sel = {1'b1, 8'h00};
    endcase
  end

  assign w_load_byte = (w_state_nxt == PIXEL) ?
                       {1'b1, (w_load_idx[0] ? r_color[7:0] : r_color[15:8])} : w_setup_sel;

  always_comb begin
    w_rd_mux = 32'd0;
    case (w_reg)
      8'h00:   w_rd_mux = {7'd0, r_x1, 7'd0, r_x0};
      8'h04:   w_rd_mux = {7'd0, r_y1, 7'd0, r_y0};
      8'h08:   w_rd_mux = {16'd0, r_color};
      8'h0C:   w_rd_mux = {30'd0, r_err, w_busy};
      8'h10:   w_rd_mux = {15'd0, r_count};
      default: w_rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_x0 <= '0; r_x1 <= '0; r_y0 <= '0; r_y1 <= '0;
      r_color <= '0; r_err <= 1'b0; r_abort_pend <= 1'b0; r_count <= '0;
      r_idx <= '0; r_half_cnt <= '0; r_phase <= 1'b0;
      r_ready <= 1'b0; r_rdata <= '0; r_cmd <= 1'b0; r_we <= 1'b0;
      r_dout <= '0; r_done <= 1'b0;
    end else begin
      r_ready <= w_access;
      if (w_rd) r_rdata <= w_rd_mux;
      else if (w_access) r_rdata <= 32'd0;
      if (w_wr && !w_busy) begin
        case (w_reg)
          8'h00: begin
            if (iomem_wstrb[0]) r_x0[7:0] <= iomem_wdata[7:0];
            if (iomem_wstrb[1]) r_x0[8]   <= iomem_wdata[8];
            if (iomem_wstrb[2]) r_x1[7:0] <= iomem_wdata[23:16];
            if (iomem_wstrb[3]) r_x1[8]   <= iomem_wdata[24];
          end
          8'h04: begin
            if (iomem_wstrb[0]) r_y0[7:0] <= iomem_wdata[7:0];
            if (iomem_wstrb[1]) r_y0[8]   <= iomem_wdata[8];
            if (iomem_wstrb[2]) r_y1[7:0] <= iomem_wdata[23:16];
            if (iomem_wstrb[3]) r_y1[8]   <= iomem_wdata[24];
          end
          8'h08: begin
            if (iomem_wstrb[0]) r_color[7:0]  <= iomem_wdata[7:0];
            if (iomem_wstrb[1]) r_color[15:8] <= iomem_wdata[15:8];
          end
          default: ;
        endcase
      end
      if (w_start_err)     r_err <= 1'b1;
      else if (w_start_ok) r_err <= 1'b0;
      if (w_state_nxt == IDLE) r_abort_pend <= 1'b0;
      else if (w_busy && w_ctrl_wr && iomem_wdata[1]) r_abort_pend <= 1'b1;
      if (w_start_ok)                    r_count <= w_npix;
      else if (w_byte_end && w_abort)    r_count <= 17'd0;
      else if (w_dec)                    r_count <= r_count - 17'd1;
      if (w_load) begin
        r_idx      <= w_load_idx;
        r_phase    <= 1'b0;
        r_half_cnt <= 4'd0;
        r_we       <= 1'b0;
        r_cmd      <= w_load_byte[8];
        r_dout     <= w_load_byte[7:0];
      end else if (w_byte_end) begin
        r_phase    <= 1'b0;
        r_half_cnt <= 4'd0;
        r_we       <= 1'b0;
      end else if (w_busy) begin
        if (w_half_end) begin
          r_half_cnt <= 4'd0;
          r_phase    <= 1'b1;
          r_we       <= 1'b1;
        end else begin
          r_half_cnt <= r_half_cnt + 4'd1;
        end
      end
      r_done <= w_fin;
    end
  end

  assign iomem_ready = r_ready;
  assign iomem_rdata = r_rdata;
  assign cmd_data    = r_cmd;
  assign write_edge  = r_we;
  assign dout        = r_dout;
  assign busy        = w_busy;
  assign done        = r_done;

endmodule

// File: tb/tb_ili9341_fill_engine.sv
// Bench for ili9341_fill_engine: register vectors, strobe scoreboard, abort/reset corners.
module tb_ili9341_fill_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  wstrb = '0;
  logic [31:0] addr = '0, wdata = '0;
  logic rst1_n = 1'b0, valid1 = 1'b0, ready1, cmd1, we1, busy1, done1;
  logic rst3_n = 1'b0, valid3 = 1'b0, ready3, cmd3, we3, busy3, done3;
  logic [7:0]  dout1, dout3;
  logic [31:0] rdata1, rdata3;

  ili9341_fill_engine #(.HALF(1)) u_dut1 (
    .clk(clk), .resetn(rst1_n), .iomem_valid(valid1), .iomem_ready(ready1),
    .iomem_wstrb(wstrb), .iomem_addr(addr), .iomem_wdata(wdata), .iomem_rdata(rdata1),
    .cmd_data(cmd1), .write_edge(we1), .dout(dout1), .busy(busy1), .done(done1));

  ili9341_fill_engine #(.HALF(3)) u_dut3 (
    .clk(clk), .resetn(rst3_n), .iomem_valid(valid3), .iomem_ready(ready3),
    .iomem_wstrb(wstrb), .iomem_addr(addr), .iomem_wdata(wdata), .iomem_rdata(rdata3),
    .cmd_data(cmd3), .write_edge(we3), .dout(dout3), .busy(busy3), .done(done3));

  int n_cmp = 0, n_bad = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- scoreboards: {cmd_data, byte} per rising strobe ----------------
  logic [8:0] exp1_q[$], exp3_q[$];
  logic [8:0] e1, e3;
  bit sb_on1 = 1'b1, sb_on3 = 1'b1;
  int rises1 = 0, rises3 = 0, dones1 = 0, dones3 = 0, done_cyc1 = 0, run3 = 0;

  always @(posedge we1) begin
    rises1++;
    if (sb_on1) begin
      if (exp1_q.size() == 0) check("strobe1_unexpected", {23'd0, cmd1, dout1}, 32'h1FF);
      else begin
        e1 = exp1_q.pop_front();
        check("strobe1_byte", {23'd0, cmd1, dout1}, {23'd0, e1});
      end
    end
  end

  always @(posedge we3) begin
    rises3++;
    if (sb_on3) begin
      if (exp3_q.size() == 0) check("strobe3_unexpected", {23'd0, cmd3, dout3}, 32'h1FF);
      else begin
        e3 = exp3_q.pop_front();
        check("strobe3_byte", {23'd0, cmd3, dout3}, {23'd0, e3});
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (done1) begin dones1++; done_cyc1 = cyc; end
    if (done3) dones3++;
    if (!rst3_n) run3 = 0;
    else if (we3) run3++;
    else if (run3 != 0) begin
      check("strobe3_high_width", 32'(run3), 32'd3);
      run3 = 0;
    end
  end

  task automatic push_setup(input int sel, input int x0, input int x1, input int y0, input int y1);
    logic [8:0] b[11];
    b[0] = {1'b0, 8'h2A}; b[1] = {1'b1, 8'(x0 >> 8)}; b[2] = {1'b1, 8'(x0 & 255)};
    b[3] = {1'b1, 8'(x1 >> 8)}; b[4] = {1'b1, 8'(x1 & 255)};
    b[5] = {1'b0, 8'h2B}; b[6] = {1'b1, 8'(y0 >> 8)}; b[7] = {1'b1, 8'(y0 & 255)};
    b[8] = {1'b1, 8'(y1 >> 8)}; b[9] = {1'b1, 8'(y1 & 255)}; b[10] = {1'b0, 8'h2C};
    for (int i = 0; i < 11; i++) begin
      if (sel == 1) exp1_q.push_back(b[i]); else exp3_q.push_back(b[i]);
    end
  endtask

  task automatic push_pix(input int sel, input logic [15:0] col, input int nbytes);
    for (int i = 0; i < nbytes; i++) begin
      if (sel == 1) exp1_q.push_back({1'b1, (i % 2 == 0) ? col[15:8] : col[7:0]});
      else          exp3_q.push_back({1'b1, (i % 2 == 0) ? col[15:8] : col[7:0]});
    end
  endtask

  // ---------------- bus driver ----------------
  task automatic bus_xfer(input int sel, input logic [7:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [31:0] rd, output int ack_cyc);
    @(negedge clk);
    addr = {24'd0, a}; wdata = d; wstrb = s;
    if (sel == 1) valid1 = 1'b1; else valid3 = 1'b1;
    @(posedge clk); #1;
    check("ack_1cycle", {31'd0, (sel == 1) ? ready1 : ready3}, 32'd1);
    rd = (sel == 1) ? rdata1 : rdata3;
    ack_cyc = cyc;
    @(negedge clk);
    valid1 = 1'b0; valid3 = 1'b0; wstrb = '0;
  endtask

  task automatic wr(input int sel, input logic [7:0] a, input logic [31:0] d, output int ack_cyc);
    logic [31:0] rd;
    bus_xfer(sel, a, d, 4'hF, rd, ack_cyc);
  endtask

  task automatic rd_chk(input int sel, input logic [7:0] a, input logic [31:0] exp,
                        input string nm, output int ack_cyc);
    logic [31:0] rd;
    bus_xfer(sel, a, 32'd0, 4'h0, rd, ack_cyc);
    check(nm, rd, exp);
  endtask

  task automatic wait_done1(input int base, input int limit, input string nm);
    int k = 0;
    while (dones1 == base && k < limit) begin @(posedge clk); #2; k++; end
    check(nm, {31'd0, dones1 != base}, 32'd1);
  endtask

  // pixels remaining after edge acc+m of a HALF=1 fill of 76800 pixels
  function automatic int cnt_model(input int m);
    if (m < 26) return 76800;
    return 76800 - ((m - 26) / 4 + 1);
  endfunction

  typedef struct {
    bit          wr;
    logic [7:0]  a;
    logic [31:0] d;
    logic [3:0]  s;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[21];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, ac, base, r0, d0;
    logic [31:0] rd;
    tbl[0]  = '{0, 8'h0C, 32'h0,         4'h0, 32'h0};
    tbl[1]  = '{0, 8'h00, 32'h0,         4'h0, 32'h0};
    tbl[2]  = '{0, 8'h04, 32'h0,         4'h0, 32'h0};
    tbl[3]  = '{0, 8'h08, 32'h0,         4'h0, 32'h0};
    tbl[4]  = '{0, 8'h10, 32'h0,         4'h0, 32'h0};
    tbl[5]  = '{1, 8'h00, 32'h0105_0003, 4'hF, 32'h0};
    tbl[6]  = '{0, 8'h00, 32'h0,         4'h0, 32'h0105_0003};
    tbl[7]  = '{1, 8'h00, 32'hFFFF_FFFF, 4'h1, 32'h0};
    tbl[8]  = '{0, 8'h00, 32'h0,         4'h0, 32'h0105_00FF};
    tbl[9]  = '{1, 8'h00, 32'hFFFF_FFFF, 4'h2, 32'h0};
    tbl[10] = '{0, 8'h00, 32'h0,         4'h0, 32'h0105_01FF};
    tbl[11] = '{1, 8'h08, 32'hABCD_F800, 4'hF, 32'h0};
    tbl[12] = '{0, 8'h08, 32'h0,         4'h0, 32'h0000_F800};
    tbl[13] = '{1, 8'h08, 32'h0000_1234, 4'h2, 32'h0};
    tbl[14] = '{0, 8'h08, 32'h0,         4'h0, 32'h0000_1200};
    tbl[15] = '{1, 8'h20, 32'hFFFF_FFFF, 4'hF, 32'h0};
    tbl[16] = '{0, 8'h20, 32'h0,         4'h0, 32'h0};
    tbl[17] = '{1, 8'h04, 32'hFFFF_FFFF, 4'h4, 32'h0};
    tbl[18] = '{0, 8'h04, 32'h0,         4'h0, 32'h00FF_0000};
    tbl[19] = '{0, 8'h0C, 32'h0,         4'h0, 32'h0};
    tbl[20] = '{0, 8'h10, 32'h0,         4'h0, 32'h0};

    // ---------------- reset ----------------
    repeat (3) @(posedge clk);
    #1;
    check("rst_we1", {31'd0, we1}, 0);   check("rst_busy1", {31'd0, busy1}, 0);
    check("rst_dout1", {24'd0, dout1}, 0); check("rst_cmd1", {31'd0, cmd1}, 0);
    check("rst_done1", {31'd0, done1}, 0); check("rst_rdata1", rdata1, 0);
    check("rst_we3", {31'd0, we3}, 0);   check("rst_busy3", {31'd0, busy3}, 0);
    @(negedge clk);
    rst1_n = 1'b1; rst3_n = 1'b1;

    for (int i = 0; i < 5; i++)
      rd_chk(3, tbl[i].a, tbl[i].exp, $sformatf("reset_read3_%0d", i), ac);
    for (int i = 0; i < 21; i++) begin
      if (tbl[i].wr) bus_xfer(1, tbl[i].a, tbl[i].d, tbl[i].s, rd, ac);
      else rd_chk(1, tbl[i].a, tbl[i].exp, $sformatf("vec%0d", i), ac);
    end

    // ---------------- basic 2x2 fill, HALF=1 ----------------
    wr(1, 8'h00, 32'h0001_0000, ac);
    wr(1, 8'h04, 32'h0001_0000, ac);
    wr(1, 8'h08, 32'h0000_F800, ac);
    push_setup(1, 0, 1, 0, 1);
    push_pix(1, 16'hF800, 8);
    base = dones1; r0 = rises1;
    wr(1, 8'h0C, 32'h1, acc);
    wait_done1(base, 200, "fill1_done_seen");
    check("fill1_done_latency", 32'(done_cyc1 - acc), 32'd38);
    check("fill1_strobes", 32'(rises1 - r0), 32'd19);
    check("fill1_queue_empty", 32'(exp1_q.size()), 32'd0);
    check("fill1_busy_after", {31'd0, busy1}, 0);
    check("fill1_cmd_hold", {31'd0, cmd1}, 1);
    check("fill1_we_after", {31'd0, we1}, 0);

    // ---------------- range errors ----------------
    r0 = rises1; base = dones1;
    wr(1, 8'h00, 32'h0005_000A, ac);
    wr(1, 8'h0C, 32'h1, ac);
    rd_chk(1, 8'h0C, 32'h2, "err_x1_lt_x0", ac);
    wr(1, 8'h00, 32'h0140_0000, ac);
    wr(1, 8'h0C, 32'h1, ac);
    rd_chk(1, 8'h0C, 32'h2, "err_x1_eq_max", ac);
    wr(1, 8'h00, 32'h0001_0000, ac);
    wr(1, 8'h04, 32'h0140_0000, ac);
    wr(1, 8'h0C, 32'h1, ac);
    rd_chk(1, 8'h0C, 32'h2, "err_y1_eq_max", ac);
    repeat (10) @(posedge clk);
    #2;
    check("err_no_strobes", 32'(rises1 - r0), 32'd0);
    check("err_no_done", 32'(dones1 - base), 32'd0);
    check("err_not_busy", {31'd0, busy1}, 0);

    // ---------------- valid start clears err; busy protection ----------------
    wr(1, 8'h04, 32'h0001_0000, ac);
    push_setup(1, 0, 1, 0, 1);
    push_pix(1, 16'hF800, 8);
    base = dones1; r0 = rises1;
    wr(1, 8'h0C, 32'h1, acc);
    rd_chk(1, 8'h0C, 32'h1, "busy_err_cleared", ac);
    wr(1, 8'h08, 32'h0000_1234, ac);
    wr(1, 8'h0C, 32'h1, ac);
    wr(1, 8'h00, 32'h0005_0004, ac);
    rd_chk(1, 8'h08, 32'h0000_F800, "busy_color_kept", ac);
    rd_chk(1, 8'h00, 32'h0001_0000, "busy_xr_kept", ac);
    wait_done1(base, 200, "fill2_done_seen");
    check("fill2_done_latency", 32'(done_cyc1 - acc), 32'd38);
    repeat (60) @(posedge clk);
    #2;
    check("fill2_one_done", 32'(dones1 - base), 32'd1);
    check("fill2_strobes", 32'(rises1 - r0), 32'd19);
    check("fill2_queue_empty", 32'(exp1_q.size()), 32'd0);

    // ---------------- single pixel at the far corner ----------------
    wr(1, 8'h00, 32'h013F_013F, ac);
    wr(1, 8'h04, 32'h013F_013F, ac);
    wr(1, 8'h08, 32'h0000_A5C3, ac);
    push_setup(1, 319, 319, 319, 319);
    push_pix(1, 16'hA5C3, 2);
    base = dones1;
    wr(1, 8'h0C, 32'h1, acc);
    wait_done1(base, 200, "corner_done_seen");
    check("corner_done_latency", 32'(done_cyc1 - acc), 32'd26);
    check("corner_queue_empty", 32'(exp1_q.size()), 32'd0);

    // ---------------- full screen count tracking, then abort ----------------
    sb_on1 = 1'b0;
    wr(1, 8'h00, 32'h00EF_0000, ac);
    wr(1, 8'h04, 32'h013F_0000, ac);
    base = dones1;
    wr(1, 8'h0C, 32'h1, acc);
    rd_chk(1, 8'h10, 32'h0001_2C00, "full_count_start", ac);
    repeat (1000) @(posedge clk);
    bus_xfer(1, 8'h10, 32'd0, 4'h0, rd, ac);
    check("full_count_track_a", rd, 32'(cnt_model(ac - 1 - acc)));
    repeat (537) @(posedge clk);
    bus_xfer(1, 8'h10, 32'd0, 4'h0, rd, ac);
    check("full_count_track_b", rd, 32'(cnt_model(ac - 1 - acc)));
    wr(1, 8'h0C, 32'h2, ac);
    for (int k = 0; k < 20 && busy1; k++) @(posedge clk);
    #2;
    check("full_abort_idle", {31'd0, busy1}, 0);
    rd_chk(1, 8'h10, 32'h0, "full_abort_count0", ac);
    check("full_abort_no_done", 32'(dones1 - base), 32'd0);

    // ---------------- HALF=3 abort during a pixel strobe ----------------
    wr(3, 8'h00, 32'h0001_0000, ac);
    wr(3, 8'h04, 32'h0001_0000, ac);
    wr(3, 8'h08, 32'h0000_07E0, ac);
    push_setup(3, 0, 1, 0, 1);
    push_pix(3, 16'h07E0, 5);
    r0 = rises3; d0 = dones3;
    wr(3, 8'h0C, 32'h1, ac);
    for (int k = 0; k < 300 && (rises3 - r0) < 16; k++) @(negedge clk);
    check("h3_reached_pixel5", 32'(rises3 - r0), 32'd16);
    wr(3, 8'h0C, 32'h2, ac);
    repeat (40) @(posedge clk);
    #2;
    check("h3_abort_strobes", 32'(rises3 - r0), 32'd16);
    check("h3_abort_queue", 32'(exp3_q.size()), 32'd0);
    check("h3_abort_busy", {31'd0, busy3}, 0);
    check("h3_abort_we", {31'd0, we3}, 0);
    check("h3_abort_no_done", 32'(dones3 - d0), 32'd0);
    rd_chk(3, 8'h10, 32'h0, "h3_abort_count0", ac);

    // ---------------- HALF=3 async reset mid-fill ----------------
    sb_on3 = 1'b0;
    wr(3, 8'h0C, 32'h1, ac);
    for (int k = 0; k < 100 && !we3; k++) @(negedge clk);
    check("h3_rst_strobe_high", {31'd0, we3}, 1);
    #2;
    rst3_n = 1'b0;
    #1;
    check("h3_rst_we_immediate", {31'd0, we3}, 0);
    check("h3_rst_busy_immediate", {31'd0, busy3}, 0);
    check("h3_rst_done", {31'd0, done3}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst3_n = 1'b1;
    rd_chk(3, 8'h0C, 32'h0, "h3_rst_ctrl", ac);
    rd_chk(3, 8'h10, 32'h0, "h3_rst_count", ac);
    rd_chk(3, 8'h00, 32'h0, "h3_rst_xr", ac);
    check("h3_rst_no_done", 32'(dones3 - d0), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
